// File: rtl/la_clkgate_ctrl.sv
// Clock-gate controller: collects per-requester clock requests and sequences a
// downstream gate enable through OFF -> WAKE -> ON -> HOLD with fixed settle and linger times.
module la_clkgate_ctrl #(
    parameter int    N    = 4,
    parameter int    WAKE = 2,
    parameter int    HOLD = 8,
    parameter string PROP = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] req,
    input  logic         force_on,
    output logic [N-1:0] ack,
    output logic         en,
    output logic         active
);

    localparam int MAXC = (WAKE > HOLD) ? WAKE : HOLD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_WAKE = 2'b01,
        S_ON   = 2'b10,
        S_HOLD = 2'b11
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          any;

    assign any = (|req) | force_on;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_OFF: begin
                if (any) begin
                    state_n = S_WAKE;
                    cnt_n   = WAKE_LOAD;
                end
            end
            S_WAKE: begin
                // Requests are ignored here so the settle time is never cut short.
                if (cnt == '0) state_n = S_ON;
                else           cnt_n   = cnt - 1'b1;
            end
            S_ON: begin
                if (!any) begin
                    state_n = S_HOLD;
                    cnt_n   = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                // A request wins over expiry and skips WAKE since the clock never stopped.
                if (any) begin
                    state_n = S_ON;
                    cnt_n   = '0;
                end else if (cnt == '0) begin
                    state_n = S_OFF;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_OFF;
                cnt_n   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= S_OFF;
            cnt   <= '0;
            en    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            en    <= (state_n != S_OFF);
        end
    end

    assign active = (state == S_ON);
    assign ack    = req & {N{active}};

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
// Directed self-checking bench for la_clkgate_ctrl with N=4, WAKE=2, HOLD=8.
module tb_la_clkgate_ctrl;

    localparam int N    = 4;
    localparam int WAKE = 2;
    localparam int HOLD = 8;

    logic         clk = 1'b0;
    logic         nreset;
    logic [N-1:0] req;
    logic         force_on;
    logic [N-1:0] ack;
    logic         en;
    logic         active;

    int checks = 0;
    int errors = 0;

    la_clkgate_ctrl #(.N(N), .WAKE(WAKE), .HOLD(HOLD), .PROP("DEFAULT")) dut (
        .clk      (clk),
        .nreset   (nreset),
        .req      (req),
        .force_on (force_on),
        .ack      (ack),
        .en       (en),
        .active   (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1ns after the next rising edge; inputs are driven and outputs sampled there.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic outs(input string tag, input logic e, input logic a, input logic [N-1:0] k);
        check({tag, ".en"}, 32'(en), 32'(e));
        check({tag, ".active"}, 32'(active), 32'(a));
        check({tag, ".ack"}, 32'(ack), 32'(k));
    endtask

    initial begin
        nreset   = 1'b0;
        req      = '0;
        force_on = 1'b0;
        #2;
        outs("reset", 1'b0, 1'b0, 4'b0000);
        step(2);
        nreset = 1'b1;
        step(1);
        outs("post_reset_idle", 1'b0, 1'b0, 4'b0000);

        // Test A: request from OFF -> en at cycle 1, ack at cycle WAKE+1.
        req = 4'b0001;
        #1;
        outs("A.c0", 1'b0, 1'b0, 4'b0000);
        step(1);
        outs("A.c1", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("A.c2", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("A.c3", 1'b1, 1'b1, 4'b0001);

        // ack follows req combinationally while ON.
        req = 4'b1011;
        #1;
        outs("ON.multi", 1'b1, 1'b1, 4'b1011);

        // Test B: all requests drop in ON -> HOLD for 8 cycles, en low at 9.
        req = 4'b0000;
        #1;
        outs("B.c0", 1'b1, 1'b1, 4'b0000);
        for (int k = 1; k <= HOLD; k++) begin
            step(1);
            outs($sformatf("B.c%0d", k), 1'b1, 1'b0, 4'b0000);
        end
        step(1);
        outs("B.c9", 1'b0, 1'b0, 4'b0000);

        // WAKE is not aborted when the request vanishes.
        req = 4'b1000;
        step(1);
        req = 4'b0000;
        outs("W.c1", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("W.c2", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("W.c3_on", 1'b1, 1'b1, 4'b0000);

        // Test C: state is now ON with any=0 -> HOLD; rejoin at count 3.
        step(5);
        outs("C.hold_cnt3", 1'b1, 1'b0, 4'b0000);
        req = 4'b0100;
        #1;
        outs("C.req_in_hold", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("C.back_on", 1'b1, 1'b1, 4'b0100);

        // Test D: request arrives exactly at HOLD count 0 -> ON, en never drops.
        req = 4'b0000;
        for (int k = 1; k <= HOLD; k++) begin
            step(1);
            check($sformatf("D.en_c%0d", k), 32'(en), 32'(1));
        end
        req = 4'b0010;
        step(1);
        outs("D.rescued", 1'b1, 1'b1, 4'b0010);

        // Return to OFF before Test E.
        req = 4'b0000;
        step(HOLD + 1);
        outs("D.off", 1'b0, 1'b0, 4'b0000);

        // Test E: force_on alone powers the gate but never acks.
        force_on = 1'b1;
        step(1);
        outs("E.c1", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("E.c2", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("E.c3", 1'b1, 1'b1, 4'b0000);
        force_on = 1'b0;
        step(HOLD);
        outs("E.drop_c8", 1'b1, 1'b0, 4'b0000);
        step(1);
        outs("E.drop_c9", 1'b0, 1'b0, 4'b0000);

        // Test F: asynchronous reset mid-WAKE (counter 1).
        req = 4'b0001;
        step(1);
        outs("F.wake", 1'b1, 1'b0, 4'b0000);
        #2;
        nreset = 1'b0;
        #1;
        outs("F.async", 1'b0, 1'b0, 4'b0000);
        req = 4'b0000;
        step(1);
        nreset = 1'b1;
        step(4);
        outs("F.stay_off", 1'b0, 1'b0, 4'b0000);

        // First edge after release accepts a request.
        req = 4'b0001;
        step(1);
        outs("F.accept", 1'b1, 1'b0, 4'b0000);
        step(WAKE);
        outs("F.on", 1'b1, 1'b1, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
